// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: circular FIFO capturing writeback register writes for trace, with sticky overflow and saturating drop count
module wb_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   PCW,
    input  logic          RegWriteW,
    input  logic [4:0]    WriteRegW,
    input  logic [31:0]   ResultW,
    output logic          trace_valid,
    input  logic          trace_ready,
    output logic [31:0]   trace_pc,
    output logic [4:0]    trace_reg,
    output logic [31:0]   trace_data,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic [15:0]   drop_count
);
    localparam int AW = $clog2(DEPTH);
    logic [68:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push, pop, full, accept, drop;
    logic [68:0] head;
    always_comb begin
        push = RegWriteW && (WriteRegW != 5'd0);
        trace_valid = count != '0;
        pop = trace_valid && trace_ready;
        full = count == CW'(DEPTH);
        accept = push && (!full || pop);
        drop = push && full && !pop;
        head = mem[rd_ptr];
        trace_pc = trace_valid ? head[68:37] : '0;
        trace_reg = trace_valid ? head[36:32] : '0;
        trace_data = trace_valid ? head[31:0] : '0;
    end
    always_ff @(posedge clk) begin
        if (accept && !reset) mem[wr_ptr] <= {PCW, WriteRegW, ResultW};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
            drop_count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(accept);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + CW'(accept) - CW'(pop);
            overflow <= overflow || drop;
            drop_count <= drop_count + 16'(drop && drop_count != 16'hFFFF);
        end
    end
endmodule

// File: doc/wb_trace_fifo.md
WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

Interface
REQ-001 Parameter: DEPTH, 8, number of entries; power of two, 2..64.
REQ-002 Parameter: CW, 4, width of count output; equals log2(DEPTH)+1.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: PCW  input  32  PC of the instruction in the writeback stage.
REQ-006 Port: RegWriteW  input  1  writeback-stage register-write enable.
REQ-007 Port: WriteRegW  input  5  writeback destination register.
REQ-008 Port: ResultW  input  32  writeback result value.
REQ-009 Port: trace_valid  output  1  head entry available.
REQ-010 Port: trace_ready  input  1  consumer accepts head entry.
REQ-011 Port: trace_pc  output  32  head entry PC.
REQ-012 Port: trace_reg  output  5  head entry destination register.
REQ-013 Port: trace_data  output  32  head entry result.
REQ-014 Port: count  output  CW  number of stored entries, 0..DEPTH.
REQ-015 Port: overflow  output  1  sticky flag; set on first dropped record.
REQ-016 Port: drop_count  output  16  number of dropped records, saturating.

Function
REQ-017 Capture condition: RegWriteW=1 and WriteRegW!=0; a record {PCW, WriteRegW, ResultW} SHALL be pushed on that edge; writes to $0 and cycles with RegWriteW=0 SHALL NOT be recorded.
REQ-018 Pop: trace_valid=1 and trace_ready=1 on a rising edge removes the head entry.
REQ-019 Storage is circular with write and read pointers of log2(DEPTH) bits; pointers wrap from DEPTH-1 to 0.
REQ-020 trace_valid SHALL equal (count!=0); trace_pc/reg/data SHALL present the head entry combinationally from storage, and SHALL be 0 when count=0.
REQ-021 Latency: a captured record SHALL appear at the outputs on the cycle after capture; there is no same-cycle bypass from inputs to outputs.
REQ-022 Handshake: while trace_valid=1 and trace_ready=0, trace_pc/reg/data SHALL hold stable.
REQ-023 Count update: push only -> +1; pop only -> -1; push and pop together -> unchanged, both performed.
REQ-024 Full (count=DEPTH), push, no pop: record SHALL be dropped, storage and pointers unchanged, overflow set to 1, drop_count incremented.
REQ-025 Full, push, and pop on the same edge: pop and push both succeed, count stays DEPTH, no drop.
REQ-026 Empty with trace_ready=1 and no push: no state change and no pointer movement.
REQ-027 drop_count SHALL saturate at 16'hFFFF.
REQ-028 overflow SHALL remain 1 until reset.
REQ-029 Entries SHALL leave in capture order (FIFO ordering).

Reset
REQ-030 With reset=1 on a rising edge, the next state SHALL be: pointers=0, count=0, trace_valid=0, trace_pc/reg/data=0, overflow=0, drop_count=0.
REQ-031 Reset SHALL take priority over a simultaneous push or pop on the same edge; that record SHALL be discarded.
REQ-032 Reset asserted mid-operation SHALL discard all stored entries; storage contents need not be cleared.

Verification
REQ-033 Single capture: reset, then PCW=0x00400010, RegWriteW=1, WriteRegW=8, ResultW=0x12345678 for one cycle, trace_ready=0 -> next cycle trace_valid=1, trace_pc=0x00400010, trace_reg=8, trace_data=0x12345678, count=1; this holds while trace_ready=0.
REQ-034 Filtering: RegWriteW=1 with WriteRegW=0, then RegWriteW=0 with WriteRegW=5 -> count stays 0, trace_valid=0.
REQ-035 Fill and overflow (DEPTH=8): 10 consecutive captures with ResultW=1..10 and trace_ready=0 -> count=8, overflow=1, drop_count=2; draining with trace_ready=1 yields trace_data 1..8 in order, then trace_valid=0.
REQ-036 Full with simultaneous push/pop: 8 entries stored, then one cycle with push (ResultW=0xAA) and trace_ready=1 -> count=8, drop_count unchanged, new head=2nd entry, 0xAA becomes the last entry.
REQ-037 Wrap-around: 20 captures with trace_ready=1 every cycle -> every record emerges exactly once, in order, one cycle after capture; count never exceeds 1; overflow=0.
REQ-038 Reset mid-operation: 5 entries stored, overflow=1, then reset for one cycle coincident with a push -> count=0, trace_valid=0, overflow=0, drop_count=0; the next capture is the first entry output.
